id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline register with load-use hazard detection for the 5-stage RV32I core. It captures the main decoder's control outputs plus decoded operands each cycle and presents them to EX. It inserts a one-cycle bubble and stalls IF/ID on a load-use dependency. It also squashes the ID instruction on a taken-branch flush from EX.

Parameters:
XLEN, 32, datapath width of PC, register operands and immediate
CNT_W, 32, width of the stall and flush performance counters

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  synchronous, active-high reset
id_valid  input  1  ID holds a real instruction
id_opcode  input  7  instruction[6:0], used for rs2-usage decode
id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch  input  1 each  main-decoder control bits
id_alu_op  input  2  00 ld/st, 01 branch, 10 R-type, 11 I-type
id_pc, id_rd1, id_rd2, id_imm  input  XLEN each  PC, register-file reads, sign-extended immediate
id_rs1, id_rs2, id_rd  input  5 each  register indices
id_funct3  input  3  funct3 field
id_funct7  input  7  funct7 field
ex_flush  input  1  branch taken in EX; kill the instruction in ID
ex_valid  output  1  EX holds a real instruction
ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  output  1 each  registered control
ex_alu_op  output  2  registered ALUOp
ex_pc, ex_rd1, ex_rd2, ex_imm  output  XLEN each  registered data
ex_rs1, ex_rs2, ex_rd  output  5 each  registered indices (for forwarding)
ex_funct3  output  3  registered funct3
ex_funct7  output  7  registered funct7
stall  output  1  combinational; hold PC and IF/ID this cycle
stall_count, flush_count  output  CNT_W each  saturating event counters

Behaviour:
- Reset (synchronous, sampled at clk edge): all ex_* outputs 0, ex_valid 0, both counters 0. stall therefore 0 from the first post-reset cycle.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- Bubble = ex_valid 0, all six control bits 0, ex_alu_op 00, and all data/index fields 0.
- rs2 used = id_opcode is 0110011 (R), 0100011 (store) or 1100011 (branch). rs1 used by every opcode except 0110111 and 0010111 (LUI/AUIPC) and 1101111 (JAL).
- hazard = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((rs1 used & id_rs1 == ex_rd) | (rs2 used & id_rs2 == ex_rd)).
- stall = hazard & ~ex_flush. Purely combinational from the current ex_* state and the ID inputs.
- Next-state priority per edge:
  - reset: clear all.
  - else ex_flush: load bubble.
  - else hazard: load bubble.
  - else id_valid=0: load bubble.
  - else capture all id_* fields, ex_valid 1.
- Stall lasts exactly one cycle: the bubble clears ex_mem_read. The held instruction is then re-presented by IF/ID and captured on the next edge.
- Back-to-back loads, with the second load using the first's rd: one stall. The second load's own consumer then stalls once more.
- Writes to x0 never stall: ex_rd = 0 is excluded.
- Flush and hazard in the same cycle: flush wins, stall 0, flush_count increments, stall_count does not.
- Counters: stall_count +1 on each cycle with stall=1. flush_count +1 on each edge where ex_flush=1 and ID was valid. Both saturate at all-ones with no wrap.
- Reset mid-stall: next cycle all outputs 0, stall 0, counters 0. No partial state is retained.

Test Plan:
- Reset with all id_* inputs driven nonzero -> after the reset edge, all ex_* are 0, stall 0, counters 0. Then release with ADD x3,x1,x2 (opcode 0110011) -> next cycle ex_valid 1, ex_reg_write 1, ex_alu_op 10, ex_rd 3.
- LW x5,0(x1) followed by ADD x6,x5,x7 -> stall 1 for exactly one cycle. ex_* is a bubble, then ADD is captured. stall_count = 1.
- LW x5 followed by ADDI x6,x0,5 with id_rs2 field = 5 -> no stall, because rs2 is unused for I-type.
- LW x0 followed by ADD x1,x0,x0 -> no stall.
- LW x5 in EX, ADD using x5 in ID, ex_flush=1 in the same cycle -> stall 0, bubble loaded, flush_count 1, stall_count 0.
- With CNT_W=4, force 20 stall cycles -> stall_count holds at 15. Assert reset mid-stall -> the next cycle shows all zeros.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core: load-use hazard
// detection with a one-cycle bubble, taken-branch squash, and saturating event counters.
module id_ex_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic             id_alu_src,
    input  logic             id_mem_to_reg,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_branch,
    input  logic [1:0]       id_alu_op,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rd1,
    input  logic [XLEN-1:0]  id_rd2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [2:0]       id_funct3,
    input  logic [6:0]       id_funct7,
    input  logic             ex_flush,
    output logic             ex_valid,
    output logic             ex_alu_src,
    output logic             ex_mem_to_reg,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_branch,
    output logic [1:0]       ex_alu_op,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rd1,
    output logic [XLEN-1:0]  ex_rd2,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic [6:0]       ex_funct7,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef struct packed {
        logic            valid;
        logic            alu_src;
        logic            mem_to_reg;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic [1:0]      alu_op;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
    } ex_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    ex_t             ex_q, ex_d, id_pkt;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic            rs1_used, rs2_used, hazard;

    always_comb begin
        rs2_used = (id_opcode == OP_R) || (id_opcode == OP_STORE) || (id_opcode == OP_BRANCH);
        rs1_used = !((id_opcode == OP_LUI) || (id_opcode == OP_AUIPC) || (id_opcode == OP_JAL));
        hazard   = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && id_valid &&
                   ((rs1_used && (id_rs1 == ex_q.rd)) || (rs2_used && (id_rs2 == ex_q.rd)));
        stall    = hazard && !ex_flush;
    end

    always_comb begin
        id_pkt = '{valid: 1'b1, alu_src: id_alu_src, mem_to_reg: id_mem_to_reg,
                   reg_write: id_reg_write, mem_read: id_mem_read, mem_write: id_mem_write,
                   branch: id_branch, alu_op: id_alu_op, pc: id_pc, rd1: id_rd1, rd2: id_rd2,
                   imm: id_imm, rs1: id_rs1, rs2: id_rs2, rd: id_rd, funct3: id_funct3,
                   funct7: id_funct7};
        // Flush, hazard and an empty ID slot all collapse to the same all-zero bubble
        ex_d = '0;
        if (!ex_flush && !hazard && id_valid) begin
            ex_d = id_pkt;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ex_flush && id_valid && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_branch     = ex_q.branch;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_pc         = ex_q.pc;
    assign ex_rd1        = ex_q.rd1;
    assign ex_rd2        = ex_q.rd2;
    assign ex_imm        = ex_q.imm;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_rd         = ex_q.rd;
    assign ex_funct3     = ex_q.funct3;
    assign ex_funct7     = ex_q.funct7;
    assign stall_count   = stall_cnt_q;
    assign flush_count   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, load-use stall, x0 and
// I-type exclusions, flush priority, counter saturation and reset mid-stall.
module tb_id_ex_stage;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic [6:0]       id_opcode;
    logic             id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch;
    logic [1:0]       id_alu_op;
    logic [XLEN-1:0]  id_pc, id_rd1, id_rd2, id_imm;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic [2:0]       id_funct3;
    logic [6:0]       id_funct7;
    logic             ex_flush;
    logic             ex_valid;
    logic             ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
    logic [1:0]       ex_alu_op;
    logic [XLEN-1:0]  ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [2:0]       ex_funct3;
    logic [6:0]       ex_funct7;
    logic             stall;
    logic [CNT_W-1:0] stall_count, flush_count;

    int unsigned checks = 0;
    int unsigned passed = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
        .id_alu_op(id_alu_op), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_funct7(id_funct7), .ex_flush(ex_flush), .ex_valid(ex_valid),
        .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_alu_op(ex_alu_op), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_funct7(ex_funct7), .stall(stall), .stall_count(stall_count), .flush_count(flush_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input logic [6:0] op, input logic src, input logic m2r, input logic rw,
                            input logic mr, input logic mw, input logic br, input logic [1:0] aop);
        id_valid = 1'b1; id_opcode = op;
        id_alu_src = src; id_mem_to_reg = m2r; id_reg_write = rw;
        id_mem_read = mr; id_mem_write = mw; id_branch = br; id_alu_op = aop;
    endtask

    task automatic set_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        set_ctrl(7'b0110011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
        id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_imm = '0; id_funct3 = 3'b000; id_funct7 = 7'b0;
        id_pc = 32'h0000_0100; id_rd1 = 32'h11; id_rd2 = 32'h22;
    endtask

    task automatic set_lw(input logic [4:0] rd, input logic [4:0] rs1);
        set_ctrl(7'b0000011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        id_rd = rd; id_rs1 = rs1; id_rs2 = 5'd0; id_imm = '0; id_funct3 = 3'b010; id_funct7 = 7'b0;
        id_pc = 32'h0000_0200; id_rd1 = 32'h33; id_rd2 = 32'h0;
    endtask

    task automatic set_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2f,
                            input logic [31:0] imm);
        set_ctrl(7'b0010011, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
        id_rd = rd; id_rs1 = rs1; id_rs2 = rs2f; id_imm = imm; id_funct3 = 3'b000;
        id_funct7 = 7'b0; id_pc = 32'h0000_0300; id_rd1 = 32'h0; id_rd2 = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1; ex_flush = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        set_ctrl(7'b0110011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11);
        id_pc = 32'hDEAD_BEEF; id_rd1 = 32'h1234_5678; id_rd2 = 32'h8765_4321; id_imm = 32'hFFFF_FFF0;
        id_rs1 = 5'd7; id_rs2 = 5'd9; id_rd = 5'd11; id_funct3 = 3'b111; id_funct7 = 7'h7F;
        reset = 1'b1; ex_flush = 1'b0;
        tick();
        checks++;
        if ({ex_valid, ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_op} !== 9'b0)
            $display("FAIL reset_ctrl got %b want 0", {ex_valid, ex_alu_src, ex_mem_to_reg, ex_reg_write,
                     ex_mem_read, ex_mem_write, ex_branch, ex_alu_op});
        else passed++;
        checks++;
        if ({ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7} !== '0)
            $display("FAIL reset_data got pc=%h rd1=%h rd2=%h imm=%h rd=%0d want 0", ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rd);
        else passed++;
        checks++;
        if ({stall, stall_count, flush_count} !== 9'b0)
            $display("FAIL reset_stall_cnt got stall=%b sc=%0d fc=%0d want 0", stall, stall_count, flush_count);
        else passed++;
        reset = 1'b0;
        set_add(5'd3, 5'd1, 5'd2);
        tick();
        checks++;
        if ({ex_valid, ex_reg_write, ex_alu_op, ex_rd, ex_pc} !== {1'b1, 1'b1, 2'b10, 5'd3, 32'h0000_0100})
            $display("FAIL add_capture got v=%b rw=%b aop=%b rd=%0d pc=%h want 1 1 10 3 00000100",
                     ex_valid, ex_reg_write, ex_alu_op, ex_rd, ex_pc);
        else passed++;
    endtask

    task automatic test_load_use();
        set_lw(5'd5, 5'd1);
        tick();
        set_add(5'd6, 5'd5, 5'd7);
        #1;
        checks++;
        if (stall !== 1'b1) $display("FAIL lu_stall got %b want 1", stall); else passed++;
        tick();
        checks++;
        if ({ex_valid, ex_mem_read, ex_reg_write, ex_rd, ex_pc} !== '0)
            $display("FAIL lu_bubble got v=%b mr=%b rw=%b rd=%0d pc=%h want 0", ex_valid, ex_mem_read, ex_reg_write, ex_rd, ex_pc);
        else passed++;
        checks++;
        if (stall !== 1'b0) $display("FAIL lu_stall_one_cycle got %b want 0", stall); else passed++;
        checks++;
        if (stall_count !== 4'd1) $display("FAIL lu_stall_count got %0d want 1", stall_count); else passed++;
        tick();
        checks++;
        if ({ex_valid, ex_rd, ex_rs1, ex_rs2} !== {1'b1, 5'd6, 5'd5, 5'd7})
            $display("FAIL lu_capture got v=%b rd=%0d rs1=%0d rs2=%0d want 1 6 5 7", ex_valid, ex_rd, ex_rs1, ex_rs2);
        else passed++;
    endtask

    task automatic test_itype_no_stall();
        set_lw(5'd5, 5'd1);
        tick();
        set_addi(5'd6, 5'd0, 5'd5, 32'd5);
        #1;
        checks++;
        if (stall !== 1'b0) $display("FAIL itype_stall got %b want 0", stall); else passed++;
        tick();
        checks++;
        if ({ex_valid, ex_alu_op, ex_rd, ex_imm} !== {1'b1, 2'b11, 5'd6, 32'd5})
            $display("FAIL itype_capture got v=%b aop=%b rd=%0d imm=%0d want 1 11 6 5", ex_valid, ex_alu_op, ex_rd, ex_imm);
        else passed++;
        checks++;
        if (stall_count !== 4'd1) $display("FAIL itype_stall_count got %0d want 1", stall_count); else passed++;
    endtask

    task automatic test_x0_no_stall();
        set_lw(5'd0, 5'd1);
        tick();
        set_add(5'd1, 5'd0, 5'd0);
        #1;
        checks++;
        if (stall !== 1'b0) $display("FAIL x0_stall got %b want 0", stall); else passed++;
        tick();
        checks++;
        if ({ex_valid, ex_rd} !== {1'b1, 5'd1}) $display("FAIL x0_capture got v=%b rd=%0d want 1 1", ex_valid, ex_rd);
        else passed++;
        // Dependent but ID empty: no stall and a bubble follows
        set_lw(5'd5, 5'd1);
        tick();
        set_add(5'd6, 5'd5, 5'd7);
        id_valid = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) $display("FAIL idinv_stall got %b want 0", stall); else passed++;
        tick();
        checks++;
        if (ex_valid !== 1'b0) $display("FAIL idinv_bubble got %b want 0", ex_valid); else passed++;
    endtask

    task automatic test_flush_hazard();
        do_reset();
        set_lw(5'd5, 5'd1);
        tick();
        set_add(5'd6, 5'd5, 5'd7);
        ex_flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) $display("FAIL flush_stall got %b want 0", stall); else passed++;
        tick();
        ex_flush = 1'b0;
        checks++;
        if ({ex_valid, ex_reg_write, ex_rd} !== 7'b0) $display("FAIL flush_bubble got v=%b rw=%b rd=%0d want 0", ex_valid, ex_reg_write, ex_rd);
        else passed++;
        checks++;
        if ({flush_count, stall_count} !== {4'd1, 4'd0})
            $display("FAIL flush_counts got fc=%0d sc=%0d want 1 0", flush_count, stall_count);
        else passed++;
        tick();
        checks++;
        if ({ex_valid, ex_rd} !== {1'b1, 5'd6}) $display("FAIL flush_recapture got v=%b rd=%0d want 1 6", ex_valid, ex_rd);
        else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        set_lw(5'd5, 5'd5);
        tick();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (stall !== 1'b1) $display("FAIL sat_stall_%0d got %b want 1", i, stall); else passed++;
            tick();
            checks++;
            if (stall_count !== ((i + 1 > 15) ? 4'd15 : 4'(i + 1)))
                $display("FAIL sat_count_%0d got %0d want %0d", i, stall_count, (i + 1 > 15) ? 15 : i + 1);
            else passed++;
            tick();
        end
        checks++;
        if ({stall, stall_count} !== {1'b1, 4'd15}) $display("FAIL sat_hold got stall=%b sc=%0d want 1 15", stall, stall_count);
        else passed++;
        reset = 1'b1;
        tick();
        checks++;
        if ({ex_valid, ex_mem_read, ex_reg_write, ex_alu_op, ex_rd, ex_rs1, ex_pc, ex_rd1, ex_funct3} !== '0)
            $display("FAIL midstall_reset_ex got v=%b mr=%b rd=%0d pc=%h want 0", ex_valid, ex_mem_read, ex_rd, ex_pc);
        else passed++;
        checks++;
        if ({stall, stall_count, flush_count} !== 9'b0)
            $display("FAIL midstall_reset_cnt got stall=%b sc=%0d fc=%0d want 0", stall, stall_count, flush_count);
        else passed++;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_itype_no_stall();
        test_x0_no_stall();
        test_flush_hazard();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
